store_word_bank: RTL

- Parametrised successor to the single-byte store: DEPTH addressable entries of WIDTH bits each.
- Per-byte write masking, a registered read port with one-cycle latency, and per-entry written/valid tracking.
- Sits between the datapath and any consumer needing a small multi-entry byte/word store.
- data_out is driven only while output_enable is high.

---
 rtl/store_word_bank_if.sv | 37 +++
 rtl/store_word_bank.sv | 106 ++++++++++
 2 files changed

// File: rtl/store_word_bank_if.sv
// store_word_bank_if
//   Request/response bundle for store_word_bank.
//   Parameters: WIDTH (data bits, multiple of 8), DEPTH (entries).
//   ADDR_W = max(1, clog2(DEPTH)) is derived and not overridable.
//   Signals:
//     write_enable, write_addr, byte_mask, data_in : write request
//     read_enable, read_addr                       : read request
//     data_out, output_enable, read_hit            : registered read result
//   Modports: master (requester), slave (the store).
interface store_word_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  write_enable;
  logic [ADDR_W-1:0]     write_addr;
  logic [WIDTH/8-1:0]    byte_mask;
  logic [WIDTH-1:0]      data_in;
  logic                  read_enable;
  logic [ADDR_W-1:0]     read_addr;
  logic [WIDTH-1:0]      data_out;
  logic                  output_enable;
  logic                  read_hit;

  modport master (
    output write_enable, write_addr, byte_mask, data_in,
    output read_enable, read_addr,
    input  data_out, output_enable, read_hit
  );

  modport slave (
    input  write_enable, write_addr, byte_mask, data_in,
    input  read_enable, read_addr,
    output data_out, output_enable, read_hit
  );
endinterface

// File: rtl/store_word_bank.sv
// store_word_bank
//   DEPTH entries of WIDTH bits with per-byte write masking, a registered
//   one-cycle-latency read port and per-entry "ever written" tracking.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : synchronous active-high reset (priority over read and write)
//     bus  : store_word_bank_if.slave (write/read requests, read result)
//   Optional feature (macro STORE_WORD_BANK_BYPASS_EN):
//     when defined, a read and write to the same in-range entry in the same
//     cycle return the byte-merged new word and read_hit = old valid OR any
//     mask bit; when undefined, reads always see pre-write contents.
module store_word_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  store_word_bank_if.slave      bus
);
  localparam int BYTES  = WIDTH / 8;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic [WIDTH-1:0] data_q;
  logic             oe_q;
  logic             hit_q;

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_accept;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] rd_word;
  logic             rd_hit;

  assign wr_in_range = ({1'b0, bus.write_addr} < DEPTH_C);
  assign rd_in_range = ({1'b0, bus.read_addr}  < DEPTH_C);
  assign wr_accept   = bus.write_enable && wr_in_range;

  assign wr_old = wr_in_range ? mem[bus.write_addr] : '0;

  // Masked bytes take data_in, the rest keep the stored value.
  always_comb begin
    wr_merged = wr_old;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (bus.byte_mask[i]) begin
        wr_merged[8*i +: 8] = bus.data_in[8*i +: 8];
      end
    end
  end

`ifdef STORE_WORD_BANK_BYPASS_EN
  logic same_addr;
  assign same_addr = wr_accept && (bus.write_addr == bus.read_addr);
`endif

  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b0;
    if (rd_in_range) begin
      rd_word = mem[bus.read_addr];
      rd_hit  = valid[bus.read_addr];
    end
`ifdef STORE_WORD_BANK_BYPASS_EN
    if (same_addr) begin
      rd_word = wr_merged;
      rd_hit  = rd_hit | (|bus.byte_mask);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        mem[e] <= '0;
      end
      valid <= '0;
    end else if (wr_accept) begin
      mem[bus.write_addr] <= wr_merged;
      if (|bus.byte_mask) begin
        valid[bus.write_addr] <= 1'b1;
      end
    end
  end

  // Result registers are zeroed on idle cycles so data_out never holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q   <= 1'b0;
      data_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      oe_q   <= bus.read_enable;
      data_q <= bus.read_enable ? rd_word : '0;
      hit_q  <= bus.read_enable && rd_hit;
    end
  end

  assign bus.data_out      = data_q;
  assign bus.output_enable = oe_q;
  assign bus.read_hit      = hit_q;
endmodule
